uart_tx_mmio: RTL

//  Memory-mapped UART transmitter that sits downstream of the load/store unit.
//  It sits beside the data RAM on the same address, write-data and store-enable wires.
//  CPU stores to TX_ADDR enqueue one byte into a FIFO; a baud-rate FSM serialises it as 8N1 on uart_tx.

---
 rtl/uart_tx_mmio.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO that a
// baud-rate FSM drains onto uart_tx; a status word is readable at STAT_ADDR.
module uart_tx_mmio #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] TX_ADDR    = 32'h0001_FFF0,
    parameter logic [31:0] STAT_ADDR  = 32'h0001_FFF4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_store,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_value,
    output logic [31:0] rdata,
    output logic        rsel,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_reg, tx_next;
    logic          pop;
    logic          baud_end;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    fifo_head;
    logic          overflow;

    logic push_req, clr_req, full, push, drop;
    logic unused_write_bits;

    assign push_req = is_store && (mem_address == TX_ADDR);
    assign clr_req  = is_store && (mem_address == STAT_ADDR) && write_value[2];
    assign full     = (count == FULL_COUNT);
    // Full is judged on the pre-edge count, so a same-edge pop cannot save the store.
    assign push     = push_req && !full;
    assign drop     = push_req && full;

    assign fifo_head         = fifo_mem[rd_ptr];
    assign unused_write_bits = ^write_value[31:8];

    // NOTE: the storage array is not reset; only pointers and count need a known value.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= write_value[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_req) begin
            overflow <= 1'b0;
        end
    end

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx_reg;
        pop        = 1'b0;

        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = shift[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                        bit_next   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx_reg   <= tx_next;
        end
    end

    assign uart_tx = tx_reg;
    assign tx_busy = (count != '0) || (state != IDLE);
    assign rsel    = (mem_address == STAT_ADDR);
    assign rdata   = rsel ? {29'b0, overflow, full, tx_busy} : 32'b0;

endmodule
